// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the FIFO write port.
//   req_valid/req_last/req_data : per-requester stream in (requester i at slice i)
//   req_ready                   : per-requester ready, at most one bit high
//   fifo_full                   : FIFO full flag (registered inside the FIFO)
//   fifo_w_en/fifo_data         : FIFO write port
//   grant_id/busy/burst_cnt     : arbiter status
// Modport master is the arbiter; slave is the surrounding logic (requesters + FIFO).
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = 2
);
    localparam int unsigned CntWidth = $clog2(MAX_BURST) + 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;
    logic [CntWidth-1:0]           burst_cnt;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data, grant_id, busy, burst_cnt
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data, grant_id, busy, burst_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// A granted requester owns the port for one burst, ending on req_last or after
// MAX_BURST words; one IDLE bubble separates bursts. Writes are gated by fifo_full.
// Ports:
//   clk : write-domain clock (FIFO wclk)
//   rst : asynchronous active-low reset
//   bus : fifo_wr_arbiter_if.master (requester streams, FIFO write port, status)
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned CntWidth = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                        state_q, state_d;
    logic [ID_WIDTH-1:0]           grant_q, grant_d;
    logic [ID_WIDTH-1:0]           ptr_q, ptr_d;
    logic [CntWidth-1:0]           cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]           sel;
    logic                          any_valid;
    logic [NUM_REQ-1:0]            valid_shift, last_shift;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_shift;
    logic                          valid_g, last_g, cnt_wrap, xfer;

    // First valid requester after ptr, scanning ptr+1, ptr+2, ... modulo NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_WIDTH-1:0] ptr);
        logic [ID_WIDTH-1:0] pick;
        logic                hit;
        int unsigned         idx;
        logic [NUM_REQ-1:0]  v;
        pick = ptr;
        hit  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            v   = valid >> idx;
            if (!hit && v[0]) begin
                pick = ID_WIDTH'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign sel       = rr_pick(bus.req_valid, ptr_q);
    assign any_valid = |bus.req_valid;

    // Shift-based selection of the granted lane avoids wide variable indexing.
    assign valid_shift = bus.req_valid >> grant_q;
    assign last_shift  = bus.req_last >> grant_q;
    assign data_shift  = bus.req_data >> (32'(grant_q) * DATA_WIDTH);
    assign valid_g     = valid_shift[0];
    assign last_g      = last_shift[0];
    assign cnt_wrap    = (32'(cnt_q) + 32'd1) == MAX_BURST;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        xfer          = 1'b0;
        bus.req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = sel;
                    ptr_d   = sel;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // Grant is held through valid gaps and full stalls; no timeout.
                if (!bus.fifo_full) begin
                    bus.req_ready = NUM_REQ'(1) << grant_q;
                end
                xfer = valid_g & ~bus.fifo_full;
                if (xfer) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (last_g || cnt_wrap) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fifo_w_en = xfer;
    assign bus.fifo_data = data_shift[DATA_WIDTH-1:0];
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == StBurst);
    assign bus.burst_cnt = cnt_q;
endmodule
